dl_rr_reg_arb: RTL and testbench
================================

DL_RR_REG_ARB -- requirements
Module: dl_rr_reg_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters; legal range 2..16.
REQ-002 Parameter NUM_BITS, default 32, width of the shared register.
REQ-003 Parameter RST_VAL, default 0, reset value of q.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 req  input  NUM_REQ  per-requester write request.
REQ-007 wdata  input  NUM_REQ*NUM_BITS  requester i data in bits [i*NUM_BITS +: NUM_BITS].
REQ-008 lock  input  NUM_REQ  per-requester grant-hold request; present only when DL_RR_ARB_LOCK_EN is defined.
REQ-009 gnt  output  NUM_REQ  one-hot combinational grant, same cycle as req.
REQ-010 q  output  NUM_BITS  shared register contents.
REQ-011 q_owner  output  $clog2(NUM_REQ)  index of requester that last wrote q.
REQ-012 q_valid  output  1  q has been written at least once since reset.
REQ-013 wr_cnt  output  8  saturating count of accepted writes.

Function
REQ-014 Round-robin pointer ptr ($clog2(NUM_REQ) bits) SHALL select gnt as the first asserted req at index ptr, ptr+1, ... wrapping NUM_REQ-1 -> 0.
REQ-015 gnt SHALL be all-zero when req is all-zero or rst_n is low; never more than one bit set.
REQ-016 A write is accepted in any cycle with gnt nonzero; latency 1 cycle: q <= wdata of granted i, q_owner <= i, q_valid <= 1 at that edge.
REQ-017 On an accepted write to i, ptr SHALL become (i+1) mod NUM_REQ; with no write, ptr, q, q_owner SHALL hold.
REQ-018 For NUM_REQ not a power of two, ptr SHALL wrap from NUM_REQ-1 to 0, never take values >= NUM_REQ.
REQ-019 q_valid SHALL remain 1 after first write until reset.
REQ-020 wr_cnt SHALL increment by 1 per accepted write and saturate at 255 (no wrap).
REQ-021 Requests deasserted without grant SHALL be dropped without side effects; no request queuing.
REQ-022 With all NUM_REQ requesting continuously, each SHALL be granted exactly once per NUM_REQ cycles.

Reset
REQ-023 While rst_n low at a clk edge: q = RST_VAL, q_owner = 0, q_valid = 0, ptr = 0, wr_cnt = 0; lock state cleared.
REQ-024 Reset SHALL take precedence over a simultaneous accepted write; that write is discarded.
REQ-025 First edge after rst_n rises SHALL arbitrate normally starting from ptr = 0.

Configuration
REQ-026 Macro DL_RR_ARB_LOCK_EN: when defined, lock port exists and a lock_active flag is kept.
REQ-027 With macro: if q_valid, req[q_owner] and lock[q_owner] are all 1, gnt SHALL select q_owner regardless of ptr and ptr SHALL not advance; lock_active = 1 for that cycle.
REQ-028 With macro: lock from a non-owner, or lock without req from owner, SHALL be ignored; normal round-robin resumes the cycle the owner drops lock or req.
REQ-029 Without macro: no lock port, no lock state; behaviour is pure round-robin per REQ-014..022.

Verification
REQ-030 Reset, then req=4'b0000 for 5 cycles -> gnt=0, q=RST_VAL, q_valid=0, wr_cnt=0.
REQ-031 req=4'b1111 held 8 cycles, wdata_i=i+0xA0 -> gnt sequence 0,1,2,3,0,1,2,3; q_owner lags gnt by 1; q=0xA3 after 4th write; wr_cnt=8.
REQ-032 ptr=2, req=4'b0011 -> gnt=4'b0001 (wrap), next ptr=1.
REQ-033 req=4'b0001 held 300 cycles -> wr_cnt saturates at 255, q_owner=0 throughout.
REQ-034 rst_n low in same cycle as gnt=4'b0100 -> q=RST_VAL, q_valid=0, ptr=0 after edge.
REQ-035 With DL_RR_ARB_LOCK_EN: owner 1 holds req[1]&lock[1] 3 cycles while req=4'b1111 -> gnt=4'b0010 each cycle; after lock drop gnt=4'b0100.

Source files
------------

// File: rtl/dl_rr_reg_arb.sv
`default_nettype none
// ============================================================================
// Module   : dl_rr_reg_arb
// Purpose  : Round-robin arbitrated shared register. NUM_REQ requesters
//            compete to write one NUM_BITS register. The grant is
//            combinational and one-hot, and the write lands on the next edge.
//            The build macro DL_RR_ARB_LOCK_EN adds a per-requester lock.
//            With the lock, the last writer keeps the grant while it holds
//            both req and lock.
// Revision : 1.0 - initial release
// ============================================================================
module dl_rr_reg_arb #(
    parameter int                  NUM_REQ  = 4,
    parameter int                  NUM_BITS = 32,
    parameter logic [NUM_BITS-1:0] RST_VAL  = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*NUM_BITS-1:0]   wdata,
`ifdef DL_RR_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]            lock,
`endif
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_BITS-1:0]           q,
    output logic [$clog2(NUM_REQ)-1:0]    q_owner,
    output logic                          q_valid,
    output logic [7:0]                    wr_cnt
);

    localparam int                 c_ptr_w   = $clog2(NUM_REQ);
    // One extra bit so ptr + offset cannot overflow before the wrap.
    localparam logic [c_ptr_w:0]   c_num_req = (c_ptr_w+1)'(NUM_REQ);
    localparam logic [c_ptr_w-1:0] c_last    = c_ptr_w'(NUM_REQ - 1);

    logic [c_ptr_w-1:0]  r_ptr;
    logic [NUM_BITS-1:0] r_q;
    logic [c_ptr_w-1:0]  r_q_owner;
    logic                r_q_valid;
    logic [7:0]          r_wr_cnt;

    logic [c_ptr_w:0]    w_sum;
    logic [c_ptr_w-1:0]  w_rr_idx;
    logic                w_rr_any;
    logic                w_lock_active;
    logic [c_ptr_w-1:0]  w_gnt_idx;
    logic                w_any;
    logic [c_ptr_w-1:0]  w_ptr_next;

    // Round-robin search. Scanning from the farthest offset back to offset 0
    // lets the request nearest to ptr overwrite every other match.
    always_comb begin
        w_sum    = '0;
        w_rr_idx = '0;
        w_rr_any = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_ptr} + (c_ptr_w+1)'(k);
            if (w_sum >= c_num_req) begin
                w_sum = w_sum - c_num_req;
            end
            if (req[w_sum[c_ptr_w-1:0]]) begin
                w_rr_idx = w_sum[c_ptr_w-1:0];
                w_rr_any = 1'b1;
            end
        end
    end

`ifdef DL_RR_ARB_LOCK_EN
    // The lock counts only for the current owner, and only while that owner
    // also requests.
    assign w_lock_active = rst_n & r_q_valid & req[r_q_owner] & lock[r_q_owner];
`else
    assign w_lock_active = 1'b0;
`endif

    assign w_gnt_idx  = w_lock_active ? r_q_owner : w_rr_idx;
    assign w_any      = rst_n & (w_lock_active | w_rr_any);
    assign w_ptr_next = (w_gnt_idx == c_last) ? '0 : w_gnt_idx + c_ptr_w'(1);

    // Drive a one-hot grant from the winning index, or zero when nobody wins.
    always_comb begin
        gnt = '0;
        if (w_any) begin
            gnt = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_gnt_idx;
        end
    end

    // Register update. Reset beats a simultaneous write, and the pointer
    // stays put while a lock holds the grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr     <= '0;
            r_q       <= RST_VAL;
            r_q_owner <= '0;
            r_q_valid <= 1'b0;
            r_wr_cnt  <= 8'd0;
        end else if (w_any) begin
            r_q       <= wdata[w_gnt_idx*NUM_BITS +: NUM_BITS];
            r_q_owner <= w_gnt_idx;
            r_q_valid <= 1'b1;
            if (!w_lock_active) begin
                r_ptr <= w_ptr_next;
            end
            if (r_wr_cnt != 8'hFF) begin
                r_wr_cnt <= r_wr_cnt + 8'd1;
            end
        end
    end

    assign q       = r_q;
    assign q_owner = r_q_owner;
    assign q_valid = r_q_valid;
    assign wr_cnt  = r_wr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dl_rr_reg_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_dl_rr_reg_arb
// Purpose  : Directed self-checking bench for dl_rr_reg_arb (4 requesters,
//            32-bit register, non-zero reset value).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dl_rr_reg_arb;

    localparam int          NUM_REQ  = 4;
    localparam int          NUM_BITS = 32;
    localparam logic [31:0] RST_VAL  = 32'hDEAD_BEEF;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ*NUM_BITS-1:0] wdata;
`ifdef DL_RR_ARB_LOCK_EN
    logic [NUM_REQ-1:0]          lock;
`endif
    logic [NUM_REQ-1:0]          gnt;
    logic [NUM_BITS-1:0]         q;
    logic [1:0]                  q_owner;
    logic                        q_valid;
    logic [7:0]                  wr_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    dl_rr_reg_arb #(
        .NUM_REQ  (NUM_REQ),
        .NUM_BITS (NUM_BITS),
        .RST_VAL  (RST_VAL)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .wdata    (wdata),
`ifdef DL_RR_ARB_LOCK_EN
        .lock     (lock),
`endif
        .gnt      (gnt),
        .q        (q),
        .q_owner  (q_owner),
        .q_valid  (q_valid),
        .wr_cnt   (wr_cnt)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed stimulus with hand-computed expectations.
    initial begin
        logic [3:0] exp_g;
        int         exp_cnt;

        rst_n = 1'b0;
        req   = 4'b1111;
`ifdef DL_RR_ARB_LOCK_EN
        lock  = 4'b0000;
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            wdata[i*NUM_BITS +: NUM_BITS] = 32'hA0 + 32'(i);
        end

        // Reset state, with requests present while in reset.
        repeat (3) tick();
        check("rst_gnt_zero", 32'(gnt), 32'h0);
        check("rst_q",        q, RST_VAL);
        check("rst_q_valid",  32'(q_valid), 32'h0);
        check("rst_q_owner",  32'(q_owner), 32'h0);
        check("rst_wr_cnt",   32'(wr_cnt), 32'h0);

        // No requests for 5 cycles.
        rst_n = 1'b1;
        req   = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            #1 check($sformatf("idle_gnt%0d", i), 32'(gnt), 32'h0);
            tick();
        end
        check("idle_q",       q, RST_VAL);
        check("idle_q_valid", 32'(q_valid), 32'h0);
        check("idle_wr_cnt",  32'(wr_cnt), 32'h0);

        // All four request for 8 cycles.
        req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            exp_g = 4'b0001 << (i % 4);
            #1 check($sformatf("rr_gnt%0d", i), 32'(gnt), 32'(exp_g));
            tick();
            check($sformatf("rr_owner%0d", i), 32'(q_owner), 32'(i % 4));
            check($sformatf("rr_q%0d", i), q, 32'hA0 + 32'(i % 4));
            if (i == 3) check("rr_q_after4", q, 32'hA3);
        end
        check("rr_wr_cnt", 32'(wr_cnt), 32'd8);
        check("rr_q_valid", 32'(q_valid), 32'h1);

        // Move ptr to 2, then request 0 and 1 to exercise the wrap.
        req = 4'b0010;
        #1 check("set_ptr2_gnt", 32'(gnt), 32'h2);
        tick();
        req = 4'b0011;
        #1 check("wrap_gnt", 32'(gnt), 32'h1);
        tick();
        check("wrap_owner", 32'(q_owner), 32'h0);
        check("wrap_q", q, 32'hA0);
        #1 check("wrap_ptr1_gnt", 32'(gnt), 32'h2);
        tick();
        check("wrap_wr_cnt", 32'(wr_cnt), 32'd11);

        // Requests dropped: nothing changes.
        req = 4'b0000;
        #1 check("drop_gnt", 32'(gnt), 32'h0);
        tick();
        check("drop_q", q, 32'hA1);
        check("drop_owner", 32'(q_owner), 32'h1);
        check("drop_wr_cnt", 32'(wr_cnt), 32'd11);

        // Sparse patterns, starting with ptr at 2.
        req = 4'b1001;
        #1 check("sparse_gnt_a", 32'(gnt), 32'h8);
        tick();
        check("sparse_owner_a", 32'(q_owner), 32'h3);
        req = 4'b0110;
        #1 check("sparse_gnt_b", 32'(gnt), 32'h2);
        tick();
        check("sparse_wr_cnt", 32'(wr_cnt), 32'd13);

        // Saturation: a single requester for 300 cycles.
        req = 4'b0001;
        for (int i = 0; i < 300; i++) begin
            tick();
            exp_cnt = (14 + i > 255) ? 255 : 14 + i;
            check($sformatf("sat_owner%0d", i), 32'(q_owner), 32'h0);
            check($sformatf("sat_cnt%0d", i), 32'(wr_cnt), 32'(exp_cnt));
        end

        // Reset arriving while requester 2 is granted.
        req = 4'b0100;
        #1 check("rstw_gnt_pre", 32'(gnt), 32'h4);
        rst_n = 1'b0;
        #1 check("rstw_gnt_in_rst", 32'(gnt), 32'h0);
        tick();
        check("rstw_q", q, RST_VAL);
        check("rstw_q_valid", 32'(q_valid), 32'h0);
        check("rstw_q_owner", 32'(q_owner), 32'h0);
        check("rstw_wr_cnt", 32'(wr_cnt), 32'h0);

        // First arbitration after reset starts at ptr 0.
        rst_n = 1'b1;
        req   = 4'b1111;
        #1 check("post_rst_gnt", 32'(gnt), 32'h1);
        tick();
        check("post_rst_owner", 32'(q_owner), 32'h0);
        check("post_rst_valid", 32'(q_valid), 32'h1);
        check("post_rst_cnt", 32'(wr_cnt), 32'h1);

`ifdef DL_RR_ARB_LOCK_EN
        // Owner 1 takes the grant and then holds it with the lock.
        lock = 4'b0010;
        #1 check("lock_take_gnt", 32'(gnt), 32'h2);
        tick();
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("lock_hold_gnt%0d", i), 32'(gnt), 32'h2);
            tick();
        end
        lock = 4'b0000;
        #1 check("lock_drop_gnt", 32'(gnt), 32'h4);
        tick();
        // A lock from a requester that does not own the register is ignored.
        lock = 4'b0010;
        #1 check("lock_nonowner_gnt", 32'(gnt), 32'h8);
        tick();
        lock = 4'b0000;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
